// File: rtl/byte_mem_loader.sv
// Byte-wide CPU memory with a boot-time streaming loader and a halt mailbox.
// Reads are combinational from adr; loads and CPU stores take effect on the next rising edge.
// Backpressure: ld_ready is high only in LOAD, so at most one byte is accepted per cycle and none after loading.
module byte_mem_loader #(
    parameter int             AW        = 8,
    parameter logic [AW-1:0]  HALT_ADDR = {AW{1'b1}}
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_valid,
    input  logic [7:0]    ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    input  logic [AW-1:0] adr,
    input  logic [7:0]    writedata,
    input  logic          memwrite,
    output logic [7:0]    memdata,
    output logic          cpu_run,
    output logic          done,
    output logic [7:0]    result,
    output logic [7:0]    checksum,
    output logic [AW:0]   load_count,
    output logic          overflow
);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam int DEPTH = 1 << AW;

    state_t        state_q;
    logic          ld_ready_q;
    logic          cpu_run_q;
    logic          done_q;
    logic [7:0]    result_q;
    logic [7:0]    checksum_q;
    logic [AW:0]   load_count_q;
    logic          overflow_q;

    logic [AW:0]   load_count_d;
    logic [7:0]    checksum_d;
    logic [AW-1:0] load_addr;
    logic          load_fire;
    logic          at_last_addr;
    logic          cpu_store;
    logic          halt_hit;

    logic [7:0]    mem [DEPTH];

    // Accept/store qualifiers and the running-total next values.
    always_comb begin
        load_addr    = load_count_q[AW-1:0];
        load_fire    = ld_ready_q && ld_valid;
        at_last_addr = &load_addr;
        cpu_store    = (state_q == S_RUN) && memwrite;
        halt_hit     = cpu_store && (adr == HALT_ADDR);
        load_count_d = load_count_q + {{AW{1'b0}}, 1'b1};
        checksum_d   = checksum_q + ld_data;
    end

    // Control FSM with all status outputs registered; reset returns to LOAD from any state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_LOAD;
            ld_ready_q   <= 1'b1;
            cpu_run_q    <= 1'b0;
            done_q       <= 1'b0;
            result_q     <= 8'h00;
            checksum_q   <= 8'h00;
            load_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (load_fire) begin
                        load_count_q <= load_count_d;
                        checksum_q   <= checksum_d;
                        // The top address ends the load either way; the address never wraps.
                        if (ld_last || at_last_addr) begin
                            state_q    <= S_RUN;
                            ld_ready_q <= 1'b0;
                            cpu_run_q  <= 1'b1;
                            overflow_q <= !ld_last;
                        end
                    end
                end
                S_RUN: begin
                    if (halt_hit) begin
                        state_q   <= S_HALT;
                        cpu_run_q <= 1'b0;
                        done_q    <= 1'b1;
                        result_q  <= writedata;
                    end
                end
                S_HALT: begin
                    state_q   <= S_HALT;
                    cpu_run_q <= 1'b0;
                end
                default: begin
                    state_q    <= S_LOAD;
                    ld_ready_q <= 1'b1;
                    cpu_run_q  <= 1'b0;
                end
            endcase
        end
    end

    // Storage write port: loader bytes during LOAD, CPU stores (except the mailbox) during RUN.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (load_fire) begin
                mem[load_addr] <= ld_data;
            end else if (cpu_store && !halt_hit) begin
                mem[adr] <= writedata;
            end
        end
    end

    // Asynchronous read so the CPU can capture a byte in the cycle it drives the address.
    assign memdata    = mem[adr];

    assign ld_ready   = ld_ready_q;
    assign cpu_run    = cpu_run_q;
    assign done       = done_q;
    assign result     = result_q;
    assign checksum   = checksum_q;
    assign load_count = load_count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_byte_mem_loader.sv
// Directed bench for byte_mem_loader: an AW=8 instance for load/run/halt flow
// and an AW=4 instance for the full-memory overflow and top-address boundaries.
module tb_byte_mem_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 8-bit address instance
    logic       reset, ld_valid, ld_last, memwrite;
    logic [7:0] ld_data, writedata, adr;
    logic       ld_ready, cpu_run, done, overflow;
    logic [7:0] memdata, result, checksum;
    logic [8:0] load_count;

    // 4-bit address instance
    logic       reset4, ld_valid4, ld_last4, memwrite4;
    logic [7:0] ld_data4, writedata4;
    logic [3:0] adr4;
    logic       ld_ready4, cpu_run4, done4, overflow4;
    logic [7:0] memdata4, result4, checksum4;
    logic [4:0] load_count4;

    logic [7:0] sum;

    byte_mem_loader #(.AW(8)) dut (
        .clk(clk), .reset(reset),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .adr(adr), .writedata(writedata), .memwrite(memwrite), .memdata(memdata),
        .cpu_run(cpu_run), .done(done), .result(result), .checksum(checksum),
        .load_count(load_count), .overflow(overflow)
    );

    byte_mem_loader #(.AW(4)) dut4 (
        .clk(clk), .reset(reset4),
        .ld_valid(ld_valid4), .ld_data(ld_data4), .ld_last(ld_last4), .ld_ready(ld_ready4),
        .adr(adr4), .writedata(writedata4), .memwrite(memwrite4), .memdata(memdata4),
        .cpu_run(cpu_run4), .done(done4), .result(result4), .checksum(checksum4),
        .load_count(load_count4), .overflow(overflow4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one byte for one cycle; returns at the falling edge after the accepting edge.
    task automatic send8(input logic [7:0] d, input logic last);
        ld_valid = 1'b1; ld_data = d; ld_last = last;
        @(negedge clk);
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    task automatic send4(input logic [7:0] d, input logic last);
        ld_valid4 = 1'b1; ld_data4 = d; ld_last4 = last;
        @(negedge clk);
        ld_valid4 = 1'b0; ld_last4 = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ld_valid = 1'b0; ld_data = 8'h00; ld_last = 1'b0;
        memwrite = 1'b0; writedata = 8'h00; adr = 8'h00;
        reset4 = 1'b1; ld_valid4 = 1'b0; ld_data4 = 8'h00; ld_last4 = 1'b0;
        memwrite4 = 1'b0; writedata4 = 8'h00; adr4 = 4'h0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        check("rst_ld_ready",   ld_ready,   1);
        check("rst_cpu_run",    cpu_run,    0);
        check("rst_done",       done,       0);
        check("rst_result",     result,     0);
        check("rst_checksum",   checksum,   0);
        check("rst_load_count", load_count, 0);
        check("rst_overflow",   overflow,   0);
        reset = 1'b0; reset4 = 1'b0;

        // Gapped load: bytes on cycles 1, 4, 5
        send8(8'h11, 1'b0);
        @(negedge clk);
        check("gap_ld_ready", ld_ready, 1);
        @(negedge clk);
        send8(8'h22, 1'b0);
        send8(8'h33, 1'b0);
        check("gap_load_count", load_count, 3);
        check("gap_checksum",   checksum,   8'h66);
        check("gap_cpu_run",    cpu_run,    0);

        // Reset mid-load keeps the partial image
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_load_count", load_count, 0);
        check("midrst_checksum",   checksum,   0);
        adr = 8'h00; #1 check("midrst_mem0", memdata, 8'h11);
        adr = 8'h01; #1 check("midrst_mem1", memdata, 8'h22);
        adr = 8'h02; #1 check("midrst_mem2", memdata, 8'h33);

        // Program image 80 02 00 03, last on the fourth byte
        send8(8'h80, 1'b0);
        send8(8'h02, 1'b0);
        send8(8'h00, 1'b0);
        check("img_run_before_last", cpu_run, 0);
        send8(8'h03, 1'b1);
        check("img_cpu_run",    cpu_run,    1);
        check("img_load_count", load_count, 4);
        check("img_checksum",   checksum,   8'h85);
        check("img_overflow",   overflow,   0);
        check("img_ld_ready",   ld_ready,   0);
        adr = 8'h00; #1 check("img_mem0", memdata, 8'h80);
        adr = 8'h01; #1 check("img_mem1", memdata, 8'h02);
        adr = 8'h02; #1 check("img_mem2", memdata, 8'h00);
        adr = 8'h03; #1 check("img_mem3", memdata, 8'h03);

        // Loader ignored in RUN
        send8(8'hEE, 1'b0);
        check("run_ld_ignored_cnt", load_count, 4);
        adr = 8'h04; #1 check("run_ld_ignored_mem", memdata === 8'hEE, 0);

        // CPU stores in RUN, with old/new byte around the write edge
        @(negedge clk);
        adr = 8'h10; writedata = 8'h5A; memwrite = 1'b1;
        @(negedge clk);
        memwrite = 1'b0;
        check("store_5a", memdata, 8'h5A);
        writedata = 8'h6B; memwrite = 1'b1;
        #1 check("store_old_before_edge", memdata, 8'h5A);
        @(negedge clk);
        memwrite = 1'b0;
        check("store_new_after_edge", memdata, 8'h6B);
        check("store_no_done", done, 0);

        // CPU-side sum of the image, stored to the mailbox
        sum = 8'h00;
        for (int i = 0; i < 4; i++) begin
            adr = 8'(i);
            @(negedge clk);
            sum = sum + memdata;
        end
        adr = 8'hFF; writedata = sum; memwrite = 1'b1;
        @(negedge clk);
        memwrite = 1'b0;
        check("halt_done",    done,    1);
        check("halt_result",  result,  8'h85);
        check("halt_cpu_run", cpu_run, 0);

        // Stores ignored in HALT
        adr = 8'h10; writedata = 8'h99; memwrite = 1'b1;
        @(negedge clk);
        memwrite = 1'b0;
        check("halt_store_ignored", memdata, 8'h6B);
        check("halt_result_held",   result,  8'h85);
        check("halt_count_held",    load_count, 4);

        // Reset out of HALT, then a CPU store during LOAD is ignored
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst2_done",     done,     0);
        check("rst2_ld_ready", ld_ready, 1);
        adr = 8'h10; writedata = 8'hA5; memwrite = 1'b1;
        @(negedge clk);
        memwrite = 1'b0;
        check("load_store_ignored", memdata, 8'h6B);
        check("load_store_cnt",     load_count, 0);

        // AW=4: fill all 16 bytes without ld_last
        for (int i = 0; i < 16; i++) send4(8'(3 * i + 1), 1'b0);
        check("ovf_overflow",   overflow4,   1);
        check("ovf_cpu_run",    cpu_run4,    1);
        check("ovf_load_count", load_count4, 16);
        check("ovf_ld_ready",   ld_ready4,   0);
        check("ovf_checksum",   checksum4,   8'h78);
        send4(8'hFF, 1'b0);
        check("ovf_17th_cnt", load_count4, 16);
        adr4 = 4'h0; #1 check("ovf_no_wrap_mem0", memdata4, 8'h01);
        adr4 = 4'hF; #1 check("ovf_mem15", memdata4, 8'h2E);

        // AW=4 mailbox at the top address
        @(negedge clk);
        adr4 = 4'hF; writedata4 = 8'h07; memwrite4 = 1'b1;
        @(negedge clk);
        memwrite4 = 1'b0;
        check("mbox_done",    done4,    1);
        check("mbox_result",  result4,  8'h07);
        check("mbox_cpu_run", cpu_run4, 0);
        check("mbox_mem15",   memdata4, 8'h2E);

        // AW=4: last byte exactly at the top address
        reset4 = 1'b1;
        @(negedge clk);
        reset4 = 1'b0;
        check("rst4_overflow", overflow4, 0);
        for (int i = 0; i < 16; i++) send4(8'(i), i == 15);
        check("full_last_overflow", overflow4,   0);
        check("full_last_cpu_run",  cpu_run4,    1);
        check("full_last_count",    load_count4, 16);

        // Reset while in RUN drops cpu_run after the reset edge
        reset4 = 1'b1;
        @(negedge clk);
        check("rst_in_run_cpu_run", cpu_run4, 0);
        reset4 = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/byte_mem_loader.md
# byte_mem_loader

Byte-wide program/data memory that serves the multicycle CPU's memory port (address, write data, write strobe, read data) and also loads that memory from an external byte stream before the CPU runs. After reset it accepts program bytes over a valid/ready handshake and writes them from address 0 upward. It then holds the CPU in reset until loading completes, releases it, and stops it again when the program writes to a halt mailbox address. It sits between the testbench or boot source and the CPU datapath's memory interface.

## Interface
- AW, 8, address width; memory holds 2^AW bytes
- HALT_ADDR, 2^AW-1, CPU write to this address is the halt mailbox
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- ld_valid  in  1  load byte offered
- ld_data  in  8  load byte
- ld_last  in  1  qualifies ld_data as final byte of the image
- ld_ready  out  1  loader accepts a byte this cycle
- adr  in  AW  CPU memory address
- writedata  in  8  CPU store data
- memwrite  in  1  CPU store strobe
- memdata  out  8  read data, combinational from adr
- cpu_run  out  1  high = CPU out of reset; wire to CPU active-low reset input
- done  out  1  halt mailbox written
- result  out  8  byte written to mailbox
- checksum  out  8  mod-256 sum of all loaded bytes
- load_count  out  AW+1  bytes accepted since reset
- overflow  out  1  memory filled without ld_last

## Operation
- States: LOAD, RUN, HALT. Reset enters LOAD from any state.
- Reset values: state LOAD, ld_ready 1, cpu_run 0, done 0, result 0, checksum 0, load_count 0, overflow 0. Memory contents are not cleared.
- LOAD:
  - ld_ready=1.
  - Transfer when ld_valid&ld_ready: mem[load_count[AW-1:0]] <= ld_data, load_count+1, checksum <= checksum+ld_data (8-bit wrap).
  - Transfer with ld_last=1 -> RUN.
  - Transfer at address 2^AW-1 with ld_last=0 -> RUN with overflow<=1. The address never wraps.
  - Transfer at 2^AW-1 with ld_last=1 -> RUN, overflow stays 0.
  - CPU memwrite ignored.
- RUN:
  - ld_ready=0; ld_valid ignored.
  - memwrite=1 with adr!=HALT_ADDR: mem[adr] <= writedata at the edge.
  - memwrite=1 with adr==HALT_ADDR: memory not written, result <= writedata, done <= 1, -> HALT.
- HALT: cpu_run=0, ld_ready=0, memwrite ignored. Exits only on reset.
- memdata = mem[adr] in every state. The read is asynchronous so the CPU can latch an instruction byte in the same cycle it presents the address.
- A read of an address written on the same edge returns the old byte before the edge and the new byte after it.
- cpu_run = (state==RUN), registered.

## Timing
- Load throughput: one byte per cycle while ld_valid is held high.
- cpu_run rises on the edge that accepts the last byte, so it is high in the next cycle.
- CPU store latency: one edge. done/result update on the same edge as the mailbox write; cpu_run is low from the next cycle.
- Reset asserted mid-load: the partial image stays in memory, counters restart at 0, and the next load overwrites from address 0.
- Reset asserted in RUN: cpu_run drops the cycle after the reset edge.
- load_count and checksum hold their values in RUN and HALT.

## Test plan
- Load 4 bytes 0x80,0x02,0x00,0x03, ld_last on the 4th -> mem[0..3] hold those bytes, load_count=4, checksum=0x85, cpu_run=1 one cycle after the 4th accept, overflow=0.
- Gap in ld_valid (bytes on cycles 1, 4, 5) -> only 3 writes at addresses 0, 1, 2. Then reset mid-load -> load_count=0, checksum=0, and mem[0..2] still read back the 3 bytes.
- AW=4: send 16 bytes without ld_last -> overflow=1, state RUN, load_count=16. A 17th ld_valid is not accepted (ld_ready=0).
- In RUN, memwrite adr=0x10 data=0x5A -> memdata at adr 0x10 reads 0x5A next cycle. The same write during LOAD leaves mem[0x10] unchanged.
- In RUN, memwrite adr=0xFF data=0x07 -> done=1, result=0x07, cpu_run=0 next cycle, mem[0xFF] unchanged. A later memwrite has no effect until reset.
- Full system: load a program that computes a sum and stores it with sb to 0xFF -> done rises and result matches the expected value.
